// File: rtl/dist_obstacle_filter.sv
// Smooths ultrasonic range readings with a 4-sample moving average and derives a debounced,
// hysteretic obstacle flag. Zero readings are treated as missing echoes.
module dist_obstacle_filter #(
   parameter int unsigned SAMPLE_PERIOD = 600_000,
   parameter int unsigned NEAR_CM       = 70,
   parameter int unsigned FAR_CM        = 80,
   parameter int unsigned DEBOUNCE      = 3,
   parameter int unsigned MAX_INVALID   = 4
) (
   input  logic        clk_50M,
   input  logic        reset,
   input  logic [15:0] distance_in,
   output logic [15:0] filt_dist,
   output logic        filt_valid,
   output logic        new_sample,
   output logic        obstacle
);

   localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   typedef enum logic [1:0] {StFill, StTrack, StLost} state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [3:0][15:0]  win_q, win_d;
   logic [17:0]       sum_q, sum_d;
   logic [2:0]        fill_cnt_q, fill_cnt_d;
   logic [3:0]        invalid_cnt_q, invalid_cnt_d;
   logic [3:0]        near_cnt_q, near_cnt_d;
   logic [3:0]        far_cnt_q, far_cnt_d;
   logic              upd_q, upd_d;
   logic [15:0]       filt_dist_q, filt_dist_d;
   logic              filt_valid_q, filt_valid_d;
   logic              new_sample_q, new_sample_d;
   logic              obstacle_q, obstacle_d;
   logic              tick;
   logic [15:0]       avg;

   assign tick = (timer_q == TW'(SAMPLE_PERIOD - 1));
   assign avg  = sum_q[17:2];

   always_comb begin
      state_d       = state_q;
      timer_d       = tick ? '0 : timer_q + TW'(1);
      win_d         = win_q;
      sum_d         = sum_q;
      fill_cnt_d    = fill_cnt_q;
      invalid_cnt_d = invalid_cnt_q;
      near_cnt_d    = near_cnt_q;
      far_cnt_d     = far_cnt_q;
      upd_d         = 1'b0;
      filt_dist_d   = filt_dist_q;
      filt_valid_d  = filt_valid_q;
      new_sample_d  = 1'b0;
      obstacle_d    = obstacle_q;

      // Publish the average one edge after the window shift, once the sum has settled
      if (upd_q) begin
         filt_dist_d  = avg;
         filt_valid_d = 1'b1;
         new_sample_d = 1'b1;
         if (avg < 16'(NEAR_CM)) begin
            far_cnt_d = '0;
            if (near_cnt_q != 4'(DEBOUNCE)) near_cnt_d = near_cnt_q + 4'd1;
            if (near_cnt_d == 4'(DEBOUNCE)) obstacle_d = 1'b1;
         end else if (avg >= 16'(FAR_CM)) begin
            near_cnt_d = '0;
            if (far_cnt_q != 4'(DEBOUNCE)) far_cnt_d = far_cnt_q + 4'd1;
            if (far_cnt_d == 4'(DEBOUNCE)) obstacle_d = 1'b0;
         end else begin
            near_cnt_d = '0;
            far_cnt_d  = '0;
         end
      end

      unique case (state_q)
         StFill, StTrack: begin
            if (tick) begin
               if (distance_in != 16'd0) begin
                  win_d         = {win_q[2:0], distance_in};
                  sum_d         = sum_q + 18'(distance_in) - 18'(win_q[3]);
                  invalid_cnt_d = '0;
                  if (state_q == StTrack) begin
                     upd_d = 1'b1;
                  end else if (fill_cnt_q == 3'd3) begin
                     fill_cnt_d = fill_cnt_q + 3'd1;
                     state_d    = StTrack;
                     upd_d      = 1'b1;
                  end else begin
                     fill_cnt_d = fill_cnt_q + 3'd1;
                  end
               end else begin
                  if (invalid_cnt_q != 4'(MAX_INVALID)) invalid_cnt_d = invalid_cnt_q + 4'd1;
                  if (invalid_cnt_q == 4'(MAX_INVALID - 1)) state_d = StLost;
               end
            end
         end
         StLost: begin
            win_d        = '0;
            sum_d        = '0;
            fill_cnt_d   = '0;
            near_cnt_d   = '0;
            far_cnt_d    = '0;
            filt_dist_d  = '0;
            filt_valid_d = 1'b0;
            obstacle_d   = 1'b0;
            state_d      = StFill;
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         state_q       <= StFill;
         timer_q       <= '0;
         win_q         <= '0;
         sum_q         <= '0;
         fill_cnt_q    <= '0;
         invalid_cnt_q <= '0;
         near_cnt_q    <= '0;
         far_cnt_q     <= '0;
         upd_q         <= 1'b0;
         filt_dist_q   <= '0;
         filt_valid_q  <= 1'b0;
         new_sample_q  <= 1'b0;
         obstacle_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         win_q         <= win_d;
         sum_q         <= sum_d;
         fill_cnt_q    <= fill_cnt_d;
         invalid_cnt_q <= invalid_cnt_d;
         near_cnt_q    <= near_cnt_d;
         far_cnt_q     <= far_cnt_d;
         upd_q         <= upd_d;
         filt_dist_q   <= filt_dist_d;
         filt_valid_q  <= filt_valid_d;
         new_sample_q  <= new_sample_d;
         obstacle_q    <= obstacle_d;
      end
   end

   assign filt_dist  = filt_dist_q;
   assign filt_valid = filt_valid_q;
   assign new_sample = new_sample_q;
   assign obstacle   = obstacle_q;

endmodule

// File: tb/tb_dist_obstacle_filter.sv
// Directed bench for dist_obstacle_filter with a short sample period; expected averages and
// obstacle states are hand-computed.
module tb_dist_obstacle_filter;

   localparam int unsigned P = 10;

   logic        clk_50M = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] distance_in = '0;
   logic [15:0] filt_dist;
   logic        filt_valid;
   logic        new_sample;
   logic        obstacle;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;   // edges already consumed since the last tick edge

   dist_obstacle_filter #(
      .SAMPLE_PERIOD(P),
      .NEAR_CM      (70),
      .FAR_CM       (80),
      .DEBOUNCE     (3),
      .MAX_INVALID  (4)
   ) dut (
      .clk_50M    (clk_50M),
      .reset      (reset),
      .distance_in(distance_in),
      .filt_dist  (filt_dist),
      .filt_valid (filt_valid),
      .new_sample (new_sample),
      .obstacle   (obstacle)
   );

   always #5 clk_50M = ~clk_50M;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one reading for the next tick and check outputs around the update edge
   task automatic sample(input string tag, input logic [15:0] d, input logic pulse,
                         input logic [15:0] e_dist, input logic e_valid, input logic e_obst);
      distance_in = d;
      repeat (P - k) @(posedge clk_50M);
      #1 check_eq({tag, " pre"}, {31'd0, new_sample}, 32'd0);
      @(posedge clk_50M);
      #1;
      check_eq({tag, " pulse"}, {31'd0, new_sample}, {31'd0, pulse});
      check_eq({tag, " dist"}, {16'd0, filt_dist}, {16'd0, e_dist});
      check_eq({tag, " valid"}, {31'd0, filt_valid}, {31'd0, e_valid});
      check_eq({tag, " obst"}, {31'd0, obstacle}, {31'd0, e_obst});
      @(posedge clk_50M);
      #1 check_eq({tag, " post"}, {31'd0, new_sample}, 32'd0);
      k = 2;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " dist"}, {16'd0, filt_dist}, 32'd0);
      check_eq({tag, " valid"}, {31'd0, filt_valid}, 32'd0);
      check_eq({tag, " nsmp"}, {31'd0, new_sample}, 32'd0);
      check_eq({tag, " obst"}, {31'd0, obstacle}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk_50M);
      reset = 1'b1;
      k = 0;
   endtask

   task automatic fill_and_track();
      for (int i = 0; i < 3; i++) sample("fill100", 16'd100, 1'b0, 16'd0, 1'b0, 1'b0);
      sample("first100", 16'd100, 1'b1, 16'd100, 1'b1, 1'b0);
      sample("near85", 16'd40, 1'b1, 16'd85, 1'b1, 1'b0);
      sample("near70", 16'd40, 1'b1, 16'd70, 1'b1, 1'b0);
      sample("near55", 16'd40, 1'b1, 16'd55, 1'b1, 1'b0);
      sample("near40a", 16'd40, 1'b1, 16'd40, 1'b1, 1'b0);
      sample("near40b", 16'd40, 1'b1, 16'd40, 1'b1, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk_50M);
      #1 check_all_zero("rst_init");
      release_reset();

      fill_and_track();

      // Asynchronous reset in TRACK with obstacle set
      repeat (3) @(posedge clk_50M);
      #1 reset = 1'b0;
      #2 check_all_zero("rst_mid");
      repeat (2) @(posedge clk_50M);
      release_reset();

      fill_and_track();

      sample("far55", 16'd100, 1'b1, 16'd55, 1'b1, 1'b1);
      sample("far70", 16'd100, 1'b1, 16'd70, 1'b1, 1'b1);
      sample("far85", 16'd100, 1'b1, 16'd85, 1'b1, 1'b1);
      sample("far100a", 16'd100, 1'b1, 16'd100, 1'b1, 1'b1);
      sample("far100b", 16'd100, 1'b1, 16'd100, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++) sample("zero_hold", 16'd0, 1'b0, 16'd100, 1'b1, 1'b0);
      sample("zero_lost", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) sample("refill50", 16'd50, 1'b0, 16'd0, 1'b0, 1'b0);
      sample("track50", 16'd50, 1'b1, 16'd50, 1'b1, 1'b0);

      sample("max1", 16'd65535, 1'b1, 16'd16421, 1'b1, 1'b0);
      sample("max2", 16'd65535, 1'b1, 16'd32792, 1'b1, 1'b0);
      sample("max3", 16'd65535, 1'b1, 16'd49163, 1'b1, 1'b0);
      sample("max4", 16'd65535, 1'b1, 16'd65535, 1'b1, 1'b0);
      sample("small1", 16'd1, 1'b1, 16'd49151, 1'b1, 1'b0);
      sample("small2", 16'd2, 1'b1, 16'd32768, 1'b1, 1'b0);
      sample("small3", 16'd2, 1'b1, 16'd16385, 1'b1, 1'b0);
      sample("floor7", 16'd2, 1'b1, 16'd1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
